// File: rtl/sdram_arbiter.sv
// Two-requester arbiter for one SDRAM controller port: video (64-beat read bursts, high priority)
// and CPU (single-word accesses). Defining ARB_STARVE_GUARD_EN lets the CPU break long video streaks.
module sdram_arbiter #(
  parameter int ADDR_W           = 24,
  parameter int DATA_W           = 16,
  parameter int MAX_VIDEO_STREAK = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              v_cmd_valid_i,
  output logic              v_cmd_ready_o,
  input  logic [ADDR_W-1:0] v_addr_x16_i,
  output logic              v_resp_valid_o,
  output logic [DATA_W-1:0] v_rdata_o,
  input  logic              v_ack_i,
  input  logic              c_cmd_valid_i,
  output logic              c_cmd_ready_o,
  input  logic              c_we_i,
  input  logic [ADDR_W-1:0] c_addr_x16_i,
  input  logic [DATA_W-1:0] c_wdata_i,
  input  logic [1:0]        c_wmask_i,
  output logic              c_resp_valid_o,
  output logic [DATA_W-1:0] c_rdata_o,
  input  logic              c_ack_i,
  output logic              sdram_cmd_valid_o,
  input  logic              sdram_cmd_ready_i,
  output logic              sdram_we_o,
  output logic [ADDR_W-1:0] sdram_addr_x16_o,
  output logic [DATA_W-1:0] sdram_wdata_o,
  output logic [1:0]        sdram_wmask_o,
  input  logic              sdram_resp_valid_i,
  input  logic [DATA_W-1:0] sdram_rdata_i,
  output logic              sdram_ack_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    V_CMD  = 3'd1,
    V_DATA = 3'd2,
    C_CMD  = 3'd3,
    C_DATA = 3'd4
  } state_e;

  state_e state_q, state_d;
  logic   cpu_first_s;

`ifdef ARB_STARVE_GUARD_EN
  logic [2:0] streak_q, streak_d;

  // Video-streak counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      streak_q <= 3'd0;
    end else begin
      streak_q <= streak_d;
    end
  end

  // Count video grants taken while the CPU waits; any CPU grant or idle CPU clears it
  always_comb begin
    streak_d = streak_q;
    if (state_q == IDLE) begin
      if (!c_cmd_valid_i || (state_d == C_CMD)) begin
        streak_d = 3'd0;
      end else if ((state_d == V_CMD) && (streak_q != 3'd7)) begin
        streak_d = streak_q + 3'd1;
      end else begin
        streak_d = streak_q;
      end
    end else begin
      streak_d = streak_q;
    end
  end

  assign cpu_first_s = (int'({29'd0, streak_q}) >= MAX_VIDEO_STREAK);
`else
  logic unused_streak_s;
  assign unused_streak_s = (MAX_VIDEO_STREAK != 0);
  assign cpu_first_s     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: arbitrate only in IDLE, hold the grant until the owner's ack
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (v_cmd_valid_i && c_cmd_valid_i && cpu_first_s) begin
          state_d = C_CMD;
        end else if (v_cmd_valid_i) begin
          state_d = V_CMD;
        end else if (c_cmd_valid_i) begin
          state_d = C_CMD;
        end else begin
          state_d = IDLE;
        end
      end
      V_CMD: begin
        if (!v_cmd_valid_i) begin
          state_d = IDLE;
        end else if (sdram_cmd_ready_i) begin
          state_d = V_DATA;
        end else begin
          state_d = V_CMD;
        end
      end
      V_DATA: begin
        if (v_ack_i) begin
          state_d = IDLE;
        end else begin
          state_d = V_DATA;
        end
      end
      C_CMD: begin
        if (!c_cmd_valid_i) begin
          state_d = IDLE;
        end else if (sdram_cmd_ready_i) begin
          state_d = C_DATA;
        end else begin
          state_d = C_CMD;
        end
      end
      C_DATA: begin
        if (c_ack_i) begin
          state_d = IDLE;
        end else begin
          state_d = C_DATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Steer command, response and ack paths to/from the current owner only
  always_comb begin
    v_cmd_ready_o     = 1'b0;
    c_cmd_ready_o     = 1'b0;
    sdram_cmd_valid_o = 1'b0;
    sdram_we_o        = 1'b0;
    sdram_addr_x16_o  = {ADDR_W{1'b0}};
    sdram_wdata_o     = {DATA_W{1'b0}};
    sdram_wmask_o     = 2'b00;
    v_resp_valid_o    = 1'b0;
    c_resp_valid_o    = 1'b0;
    sdram_ack_o       = 1'b0;
    case (state_q)
      V_CMD: begin
        sdram_cmd_valid_o = v_cmd_valid_i;
        v_cmd_ready_o     = v_cmd_valid_i && sdram_cmd_ready_i;
        sdram_addr_x16_o  = v_addr_x16_i;
        sdram_wmask_o     = 2'b11;
      end
      C_CMD: begin
        sdram_cmd_valid_o = c_cmd_valid_i;
        c_cmd_ready_o     = c_cmd_valid_i && sdram_cmd_ready_i;
        sdram_we_o        = c_we_i;
        sdram_addr_x16_o  = c_addr_x16_i;
        sdram_wdata_o     = c_wdata_i;
        sdram_wmask_o     = c_wmask_i;
      end
      V_DATA: begin
        v_resp_valid_o = sdram_resp_valid_i;
        sdram_ack_o    = v_ack_i;
      end
      C_DATA: begin
        c_resp_valid_o = sdram_resp_valid_i;
        sdram_ack_o    = c_ack_i;
      end
      default: begin
        sdram_cmd_valid_o = 1'b0;
      end
    endcase
  end

  assign v_rdata_o = sdram_rdata_i;
  assign c_rdata_o = sdram_rdata_i;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: owner/phase model checked every cycle plus directed
// scenarios with literal expectations. Honours ARB_STARVE_GUARD_EN like the design.
module tb_sdram_arbiter;
  logic        clk = 1'b0;
  logic        rst_i;
  logic        v_cmd_valid_i, v_cmd_ready_o, v_resp_valid_o, v_ack_i;
  logic [23:0] v_addr_x16_i;
  logic [15:0] v_rdata_o;
  logic        c_cmd_valid_i, c_cmd_ready_o, c_we_i, c_resp_valid_o, c_ack_i;
  logic [23:0] c_addr_x16_i;
  logic [15:0] c_wdata_i, c_rdata_o;
  logic [1:0]  c_wmask_i;
  logic        sdram_cmd_valid_o, sdram_cmd_ready_i, sdram_we_o, sdram_resp_valid_i, sdram_ack_o;
  logic [23:0] sdram_addr_x16_o;
  logic [15:0] sdram_wdata_o, sdram_rdata_i;
  logic [1:0]  sdram_wmask_o;

  int checks = 0;
  int errors = 0;
  int vbeats, acks_seen, c_resp_seen, c_ready_seen;
  bit glog[$];
  logic [15:0] rd;
  logic [5:0]  lg;

`ifdef ARB_STARVE_GUARD_EN
  localparam int STREAK_LIM = 4;
  localparam logic [5:0] STARVE_ORDER = 6'b111101;
`else
  localparam int STREAK_LIM = 1000;
  localparam logic [5:0] STARVE_ORDER = 6'b111110;
`endif

  sdram_arbiter #(.ADDR_W(24), .DATA_W(16), .MAX_VIDEO_STREAK(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .v_cmd_valid_i(v_cmd_valid_i), .v_cmd_ready_o(v_cmd_ready_o), .v_addr_x16_i(v_addr_x16_i),
    .v_resp_valid_o(v_resp_valid_o), .v_rdata_o(v_rdata_o), .v_ack_i(v_ack_i),
    .c_cmd_valid_i(c_cmd_valid_i), .c_cmd_ready_o(c_cmd_ready_o), .c_we_i(c_we_i),
    .c_addr_x16_i(c_addr_x16_i), .c_wdata_i(c_wdata_i), .c_wmask_i(c_wmask_i),
    .c_resp_valid_o(c_resp_valid_o), .c_rdata_o(c_rdata_o), .c_ack_i(c_ack_i),
    .sdram_cmd_valid_o(sdram_cmd_valid_o), .sdram_cmd_ready_i(sdram_cmd_ready_i),
    .sdram_we_o(sdram_we_o), .sdram_addr_x16_o(sdram_addr_x16_o), .sdram_wdata_o(sdram_wdata_o),
    .sdram_wmask_o(sdram_wmask_o), .sdram_resp_valid_i(sdram_resp_valid_i),
    .sdram_rdata_i(sdram_rdata_i), .sdram_ack_o(sdram_ack_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  // Model: who owns the port (0 none, 1 video, 2 CPU) and whether its command has been taken
  int m_owner = 0;
  bit m_acc = 1'b0;
  int m_streak = 0;
  bit started = 1'b0;
  bit own_v, own_a;

  always @(posedge clk) begin
    started <= 1'b1;
    own_v = (m_owner == 1) ? v_cmd_valid_i : c_cmd_valid_i;
    own_a = (m_owner == 1) ? v_ack_i : c_ack_i;
    if (rst_i) begin
      m_owner <= 0; m_acc <= 1'b0; m_streak <= 0;
    end else if (m_owner == 0) begin
      if (v_cmd_valid_i && !(c_cmd_valid_i && m_streak >= STREAK_LIM)) begin
        m_owner  <= 1;
        m_streak <= c_cmd_valid_i ? ((m_streak < 7) ? m_streak + 1 : 7) : 0;
      end else if (c_cmd_valid_i) begin
        m_owner <= 2; m_streak <= 0;
      end else begin
        m_streak <= 0;
      end
    end else if (!m_acc) begin
      if (own_v && sdram_cmd_ready_i) m_acc <= 1'b1;
      else if (!own_v) m_owner <= 0;
    end else if (own_a) begin
      m_owner <= 0; m_acc <= 1'b0;
    end
  end

  // Per-cycle comparison against the model, plus event counters for the scenarios
  bit cmdph, datph, e_sv, ov, oa;
  always @(negedge clk) begin
    if (started) begin
      cmdph = (m_owner != 0) && !m_acc;
      datph = (m_owner != 0) && m_acc;
      ov    = (m_owner == 1) ? v_cmd_valid_i : c_cmd_valid_i;
      oa    = (m_owner == 1) ? v_ack_i : c_ack_i;
      e_sv  = cmdph && ov;
      chk("handshake",
          64'({v_cmd_ready_o, c_cmd_ready_o, sdram_cmd_valid_o, v_resp_valid_o, c_resp_valid_o, sdram_ack_o}),
          64'({e_sv && m_owner == 1 && sdram_cmd_ready_i, e_sv && m_owner == 2 && sdram_cmd_ready_i, e_sv,
               datph && m_owner == 1 && sdram_resp_valid_i, datph && m_owner == 2 && sdram_resp_valid_i,
               datph && oa}));
      chk("rdata_fwd", 64'({v_rdata_o, c_rdata_o}), 64'({sdram_rdata_i, sdram_rdata_i}));
      if (e_sv && m_owner == 1) chk("v_cmd_fields", 64'({sdram_we_o, sdram_wmask_o, sdram_addr_x16_o}),
                                    64'({1'b0, 2'b11, v_addr_x16_i}));
      if (e_sv && m_owner == 2) chk("c_cmd_fields",
                                    64'({sdram_we_o, sdram_wmask_o, sdram_wdata_o, sdram_addr_x16_o}),
                                    64'({c_we_i, c_wmask_i, c_wdata_i, c_addr_x16_i}));
      if (sdram_resp_valid_i) chk("resp_outside_data", 64'(datph), 64'(1));
      if (sdram_ack_o) acks_seen++;
      if (c_resp_valid_o) c_resp_seen++;
      if (c_cmd_ready_o) c_ready_seen++;
    end
  end

  // SDRAM controller: high-half addresses get 64-beat bursts, others one beat (data 0x1234)
  initial begin
    int left;
    bit big, big_now, xfer, rs, rv;
    left = 0; big = 1'b0;
    sdram_resp_valid_i = 1'b0; sdram_rdata_i = 16'h0000;
    forever begin
      @(negedge clk);
      xfer = sdram_cmd_valid_o && sdram_cmd_ready_i; rs = rst_i; rv = sdram_resp_valid_i;
      big_now = sdram_addr_x16_o[23];
      @(posedge clk); #1;
      if (rs) begin
        left = 0;
      end else begin
        if (rv && left > 0) left--;
        if (xfer) begin
          left = big_now ? 64 : 1; big = big_now; glog.push_back(big_now);
        end
      end
      sdram_resp_valid_i = (left > 0);
      sdram_rdata_i = big ? 16'hA000 + 16'(64 - left) : 16'h1234;
    end
  end

  task automatic video_txn(input logic [23:0] addr, input bit chk_lat, input int abort_at);
    bit ok;
    int beats;
    v_addr_x16_i = addr; v_cmd_valid_i = 1'b1;
    if (chk_lat) begin
      @(posedge clk); #1;
      chk("v_cmd_latency", 64'({sdram_cmd_valid_o, sdram_we_o, sdram_wmask_o, sdram_addr_x16_o}),
          64'({1'b1, 1'b0, 2'b11, addr}));
    end
    ok = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk); ok = v_cmd_ready_o; @(posedge clk); #1;
    end
    v_cmd_valid_i = 1'b0;
    if (!ok) begin chk("v_grant_timeout", 64'(0), 64'(1)); return; end
    beats = 0;
    for (int n = 0; n < 500 && beats < 64; n++) begin
      @(negedge clk); if (v_resp_valid_o) beats++; @(posedge clk); #1;
      if (abort_at > 0 && beats == abort_at) begin
        rst_i = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_outputs", 64'({v_cmd_ready_o, c_cmd_ready_o, sdram_cmd_valid_o,
                                    v_resp_valid_o, c_resp_valid_o, sdram_ack_o}), 64'(0));
        rst_i = 1'b0;
        return;
      end
    end
    vbeats = beats;
    v_ack_i = 1'b1; @(posedge clk); #1; v_ack_i = 1'b0;
  endtask

  task automatic cpu_txn(input bit we, input logic [23:0] addr, input logic [15:0] wd,
                         input logic [1:0] mask, input bit chk_lat, output logic [15:0] rdata);
    bit ok;
    rdata = 16'hxxxx;
    c_we_i = we; c_addr_x16_i = addr; c_wdata_i = wd; c_wmask_i = mask; c_cmd_valid_i = 1'b1;
    if (chk_lat) begin
      @(posedge clk); #1;
      chk("c_cmd_latency", 64'({sdram_cmd_valid_o, sdram_we_o, sdram_wmask_o, sdram_wdata_o, sdram_addr_x16_o}),
          64'({1'b1, we, mask, wd, addr}));
    end
    ok = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk); ok = c_cmd_ready_o; @(posedge clk); #1;
    end
    c_cmd_valid_i = 1'b0;
    if (!ok) begin chk("c_grant_timeout", 64'(0), 64'(1)); return; end
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (c_resp_valid_o) begin ok = 1'b1; rdata = c_rdata_o; end
      @(posedge clk); #1;
    end
    if (!ok) begin chk("c_resp_timeout", 64'(0), 64'(1)); return; end
    c_ack_i = 1'b1; @(posedge clk); #1; c_ack_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; sdram_cmd_ready_i = 1'b1;
    v_cmd_valid_i = 1'b0; v_addr_x16_i = 24'h0; v_ack_i = 1'b0;
    c_cmd_valid_i = 1'b0; c_we_i = 1'b0; c_addr_x16_i = 24'h0; c_wdata_i = 16'h0;
    c_wmask_i = 2'b00; c_ack_i = 1'b0;
    acks_seen = 0; c_resp_seen = 0; c_ready_seen = 0; vbeats = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({v_cmd_ready_o, c_cmd_ready_o, sdram_cmd_valid_o, v_resp_valid_o,
                              c_resp_valid_o, sdram_ack_o}), 64'(0));
    rst_i = 1'b0;
    @(posedge clk); #1;

    // Video-only burst
    acks_seen = 0; c_resp_seen = 0;
    video_txn(24'h800000, 1'b1, 0);
    chk("v_beats", 64'(vbeats), 64'(64));
    chk("v_ack_pulses", 64'(acks_seen), 64'(1));
    chk("v_no_cpu_resp", 64'(c_resp_seen), 64'(0));

    // CPU write
    c_resp_seen = 0;
    cpu_txn(1'b1, 24'h000010, 16'hBEEF, 2'b01, 1'b1, rd);
    chk("c_wr_resp_beats", 64'(c_resp_seen), 64'(1));

    // CPU withdraws before the controller accepts
    sdram_cmd_ready_i = 1'b0; c_we_i = 1'b0; c_addr_x16_i = 24'h000044; c_cmd_valid_i = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("c_wait_valid", 64'({sdram_cmd_valid_o, c_cmd_ready_o}), 64'(2'b10));
    c_cmd_valid_i = 1'b0;
    @(posedge clk); #1;
    chk("c_withdraw_idle", 64'(sdram_cmd_valid_o), 64'(0));
    sdram_cmd_ready_i = 1'b1;
    @(posedge clk); #1;

    // Simultaneous requests: video first, CPU read afterwards
    glog.delete(); c_ready_seen = 0;
    fork
      video_txn(24'h800040, 1'b1, 0);
      cpu_txn(1'b0, 24'h000020, 16'h0000, 2'b11, 1'b0, rd);
    join
    chk("sim_grants", 64'(glog.size()), 64'(2));
    if (glog.size() == 2) chk("sim_order", 64'({glog[0], glog[1]}), 64'(2'b10));
    chk("c_rd_data", 64'(rd), 64'(16'h1234));
    chk("c_ready_once", 64'(c_ready_seen), 64'(1));

    // Reset at beat 20, then a normal burst
    vbeats = 0;
    video_txn(24'h800080, 1'b0, 20);
    video_txn(24'h800000, 1'b1, 0);
    chk("v_after_rst_beats", 64'(vbeats), 64'(64));

    // Both requesting continuously
    @(posedge clk); #1;
    glog.delete();
    fork
      begin repeat (5) video_txn(24'h800100, 1'b0, 0); end
      cpu_txn(1'b0, 24'h000030, 16'h0000, 2'b11, 1'b0, rd);
    join
    chk("starve_grants", 64'(glog.size()), 64'(6));
    lg = 6'b000000;
    foreach (glog[i]) lg = {lg[4:0], glog[i]};
    chk("starve_order", 64'(lg), 64'(STARVE_ORDER));

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
